// File: rtl/alu_div.sv
// rtl/alu_div.sv - multi-cycle restoring divider for DIV/DIVU/REM/REMU
// One quotient bit per cycle; divide-by-zero and signed overflow resolve without iterating.
module alu_div #(
  parameter int CPU_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 div_start_i,
  input  logic [1:0]           div_op_i,
  input  logic [CPU_WIDTH-1:0] dividend_i,
  input  logic [CPU_WIDTH-1:0] divisor_i,
  input  logic                 div_flush_i,
  output logic [CPU_WIDTH-1:0] div_result_o,
  output logic                 div_res_ready_o,
  output logic                 div_busy_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, next_state;

  logic        op_rem, neg_q, neg_r;
  logic [31:0] dvd, dsr, rem;
  logic [4:0]  cnt;

  logic        in_signed, in_rem, div_zero, overflow, special;
  logic [31:0] abs_dvd, abs_dsr, special_res;
  logic [32:0] rem_sh;
  logic        rem_ge;
  logic [31:0] rem_nx, quo_nx, final_res;

  assign in_signed = ~div_op_i[0];
  assign in_rem    = div_op_i[1];
  assign abs_dvd   = (in_signed && dividend_i[31]) ? -dividend_i : dividend_i;
  assign abs_dsr   = (in_signed && divisor_i[31]) ? -divisor_i : divisor_i;
  assign div_zero  = (divisor_i == 32'h0000_0000);
  assign overflow  = in_signed && (dividend_i == 32'h8000_0000) && (divisor_i == 32'hFFFF_FFFF);
  assign special   = div_zero || overflow;
  assign special_res = div_zero ? (in_rem ? dividend_i : 32'hFFFF_FFFF)
                                : (in_rem ? 32'h0000_0000 : 32'h8000_0000);

  // Partial remainder keeps a carry bit so divisors above 2^31 compare correctly.
  // The dividend register doubles as the quotient: bits shift out the top, quotient bits in the bottom.
  assign rem_sh    = {rem, dvd[31]};
  assign rem_ge    = (rem_sh >= {1'b0, dsr});
  assign rem_nx    = rem_ge ? (rem_sh[31:0] - dsr) : rem_sh[31:0];
  assign quo_nx    = {dvd[30:0], rem_ge};
  assign final_res = op_rem ? (neg_r ? -rem_nx : rem_nx) : (neg_q ? -quo_nx : quo_nx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (div_start_i && !div_flush_i) next_state = special ? DONE : CALC;
      CALC: begin
        if (div_flush_i)         next_state = IDLE;
        else if (cnt == 5'd31)   next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_rem          <= 1'b0;
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
      dvd             <= '0;
      dsr             <= '0;
      rem             <= '0;
      cnt             <= '0;
      div_result_o    <= '0;
      div_res_ready_o <= 1'b0;
      div_busy_o      <= 1'b0;
    end else begin
      div_res_ready_o <= (next_state == DONE);
      div_busy_o      <= (next_state != IDLE);
      case (state)
        IDLE: begin
          if (next_state != IDLE) begin
            op_rem <= in_rem;
            neg_q  <= in_signed && (dividend_i[31] ^ divisor_i[31]);
            neg_r  <= in_signed && dividend_i[31];
            dvd    <= abs_dvd;
            dsr    <= abs_dsr;
            rem    <= '0;
            cnt    <= '0;
          end
          if (next_state == DONE) div_result_o <= special_res;
        end
        CALC: begin
          if (!div_flush_i) begin
            dvd <= quo_nx;
            rem <= rem_nx;
            if (cnt != 5'd31) cnt <= cnt + 5'd1;
            if (next_state == DONE) div_result_o <= final_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div.sv
// tb/tb_alu_div.sv - scoreboard bench for alu_div
// Driver pushes expected result and ready cycle; a negedge monitor pops and compares.
module tb_alu_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        div_start = 1'b0;
  logic        div_flush = 1'b0;
  logic [1:0]  div_op = 2'd0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] div_result;
  logic        div_res_ready;
  logic        div_busy;

  alu_div dut (
    .clk             (clk),
    .rst             (rst),
    .div_start_i     (div_start),
    .div_op_i        (div_op),
    .dividend_i      (dividend),
    .divisor_i       (divisor),
    .div_flush_i     (div_flush),
    .div_result_o    (div_result),
    .div_res_ready_o (div_res_ready),
    .div_busy_o      (div_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    int          at;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain SystemVerilog arithmetic plus the RISC-V corner-case rules.
  function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output bit special);
    special = 1'b0;
    if (b == 32'd0) begin
      special = 1'b1;
      res = op[1] ? a : 32'hFFFF_FFFF;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      special = 1'b1;
      res = op[1] ? 32'h0 : 32'h8000_0000;
    end else begin
      case (op)
        2'd0:    res = $signed(a) / $signed(b);
        2'd1:    res = a / b;
        2'd2:    res = $signed(a) % $signed(b);
        default: res = a % b;
      endcase
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && div_res_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got ready with result %h at cycle %0d, expected none", div_result, cyc);
      end else begin
        e = sb.pop_front();
        check("result", div_result, e.res);
        check("ready_cycle", cyc, e.at);
      end
    end
  end

  // Called at a negedge; chained means the previous op kept start high through DONE.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit chained, input bit keep);
    logic [31:0] r;
    bit          sp;
    bit          seen;
    exp_t        e;
    ref_model(op, a, b, r, sp);
    e.res = r;
    e.at  = cyc + (chained ? 1 : 0) + (sp ? 1 : 33);
    sb.push_back(e);
    div_op    = op;
    dividend  = a;
    divisor   = b;
    div_start = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (k == 0 && !chained) check("busy_after_start", {31'd0, div_busy}, 32'd1);
      if (div_res_ready) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL ready_timeout: got no ready within 40 cycles, expected one (op %0d a %h b %h)", op, a, b);
    end
    if (!keep) begin
      div_start = 1'b0;
      @(negedge clk);
      check("busy_idle", {31'd0, div_busy}, 32'd0);
      check("ready_one_cycle", {31'd0, div_res_ready}, 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          prev_keep;
    bit          keep;
    logic [1:0]  op;
    logic [31:0] a, b;
    int          sel;

    repeat (2) @(negedge clk);
    check("reset_result", div_result, 32'd0);
    check("reset_ready", {31'd0, div_res_ready}, 32'd0);
    check("reset_busy", {31'd0, div_busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(2'd1, 32'd100, 32'd7, 1'b0, 1'b0);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    issue(2'd0, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    issue(2'd0, 32'd5, 32'd0, 1'b0, 1'b0);
    issue(2'd3, 32'd5, 32'd0, 1'b0, 1'b0);
    issue(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);

    issue(2'd1, 32'd100, 32'd7, 1'b0, 1'b1);
    issue(2'd1, 32'hFFFF_FFFF, 32'h10, 1'b1, 1'b0);

    // Flush on the 10th CALC cycle: no ready, result untouched.
    div_op = 2'd1; dividend = 32'd1000; divisor = 32'd3; div_start = 1'b1;
    repeat (10) @(negedge clk);
    check("busy_before_flush", {31'd0, div_busy}, 32'd1);
    div_flush = 1'b1;
    div_start = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'd0, div_busy}, 32'd0);
    check("flush_ready", {31'd0, div_res_ready}, 32'd0);
    check("flush_result_held", div_result, 32'h0FFF_FFFF);
    div_flush = 1'b0;
    repeat (40) @(negedge clk);
    issue(2'd1, 32'd9, 32'd3, 1'b0, 1'b0);

    // Flush coincident with start in IDLE blocks capture.
    div_start = 1'b1;
    div_flush = 1'b1;
    @(negedge clk);
    check("flush_blocks_start", {31'd0, div_busy}, 32'd0);
    div_start = 1'b0;
    div_flush = 1'b0;
    @(negedge clk);

    // Async reset mid-CALC clears outputs without waiting for an edge.
    div_op = 2'd1; dividend = 32'd77; divisor = 32'd5; div_start = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_result", div_result, 32'd0);
    check("async_rst_busy", {31'd0, div_busy}, 32'd0);
    check("async_rst_ready", {31'd0, div_res_ready}, 32'd0);
    div_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(2'd1, 32'd9, 32'd3, 1'b0, 1'b0);

    prev_keep = 1'b0;
    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = 32'd0;
      else if (sel == 1) b = 32'($urandom_range(1, 15));
      else if (sel == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 3) b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      else               b = $urandom >> $urandom_range(0, 31);
      keep = (i != 39) && ($urandom_range(0, 2) == 0);
      issue(op, a, b, prev_keep, keep);
      prev_keep = keep;
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending results, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
